// File: rtl/lc3_ctrl_pkg.sv
// Shared types for the LC-3 control unit: FSM states, opcodes, mux/ALU encodings
// and the packed control word that the state decoder drives.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S1, S5, S9, S22, S12, S4, S21, S20,
    S6, S25, S27, S7, S23, S16,
    PAUSE_IR1, PAUSE_IR2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  typedef enum logic [1:0] {PCMUX_PC1, PCMUX_BUS, PCMUX_ADDER} pcmux_e;
  typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2mux_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASSA} aluk_e;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc, ld_ben, ld_reg;
    logic       gatepc, gatemdr, gatealu, gatemarmux;
    logic       drmux, sr1mux, sr2mux, addr1mux, mio_en;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
  } ctrl_t;

  // Everything idle; the SRAM strobes are active-low so idle means 1.
  localparam ctrl_t CTRL_IDLE = '{mem_ce: 1'b1, mem_ub: 1'b1, mem_lb: 1'b1,
                                  mem_oe: 1'b1, mem_we: 1'b1, default: '0};

endpackage

// File: rtl/lc3_control_if.sv
// Datapath-facing bundle of the LC-3 control unit: IR/branch status in, control word out.
interface lc3_control_if;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG;
  logic       GATEPC, GATEMDR, GATEALU, GATEMARMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG,
    output GATEPC, GATEMDR, GATEALU, GATEMARMUX,
    output DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
    output PCMUX, ADDR2MUX, ALUK,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG,
    input  GATEPC, GATEMDR, GATEALU, GATEMARMUX,
    input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
    input  PCMUX, ADDR2MUX, ALUK,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating down-counter that stretches an SRAM access to MEM_WAIT cycles.
// Start loads MEM_WAIT-1; Done is high once the count has reached zero.
module mem_wait_timer #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Done
);

  localparam logic [1:0] LOAD = 2'(MEM_WAIT - 1);

  logic [1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)              r_count <= '0;
    else if (Start)          r_count <= LOAD;
    else if (r_count != '0)  r_count <= r_count - 2'd1;
  end

  assign Done = (r_count == '0);

endmodule

// File: rtl/lc3_control.sv
// LC-3 Moore control FSM: fetch/decode/execute sequencing with stretched SRAM accesses.
// Define LC3_PAUSE_EN to enable the PAUSE instruction (opcode 1101) and the Continue handshake.
module lc3_control
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          Continue,
  lc3_control_if.master bus
);

  state_t r_state, w_next;
  ctrl_t  w_ctrl;
  logic   w_timer_start, w_timer_done;

  // The timer is armed in the single state that precedes each memory wait state.
  assign w_timer_start = (r_state == S18) || (r_state == S6) || (r_state == S23);

  mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (w_timer_start),
    .Done  (w_timer_done)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= HALTED;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    w_next = r_state;
    w_ctrl = CTRL_IDLE;
    case (r_state)
      HALTED: if (Run) w_next = S18;
      S18: begin
        w_ctrl.gatepc = 1'b1; w_ctrl.ld_mar = 1'b1; w_ctrl.ld_pc = 1'b1;
        w_ctrl.pcmux  = PCMUX_PC1;
        w_next = S33;
      end
      S33, S25: begin
        w_ctrl.mem_ce = 1'b0; w_ctrl.mem_oe = 1'b0;
        w_ctrl.mio_en = 1'b1; w_ctrl.ld_mdr = 1'b1;
        if (w_timer_done) w_next = (r_state == S33) ? S35 : S27;
      end
      S35: begin
        w_ctrl.gatemdr = 1'b1; w_ctrl.ld_ir = 1'b1;
        w_next = S32;
      end
      S32: begin
        w_ctrl.ld_ben = 1'b1;
        case (bus.Opcode)
          OP_ADD:  w_next = S1;
          OP_AND:  w_next = S5;
          OP_NOT:  w_next = S9;
          OP_BR:   w_next = bus.BEN ? S22 : S18;
          OP_JMP:  w_next = S12;
          OP_JSR:  w_next = S4;
          OP_LDR:  w_next = S6;
          OP_STR:  w_next = S7;
`ifdef LC3_PAUSE_EN
          OP_PAUSE: w_next = PAUSE_IR1;
`else
          OP_PAUSE: w_next = S18;
`endif
          default: w_next = S18;
        endcase
      end
      S1, S5, S9: begin
        w_ctrl.sr1mux  = 1'b1; w_ctrl.sr2mux = bus.IR_5;
        w_ctrl.gatealu = 1'b1; w_ctrl.ld_reg = 1'b1; w_ctrl.ld_cc = 1'b1;
        w_ctrl.aluk    = (r_state == S1) ? ALU_ADD : (r_state == S5) ? ALU_AND : ALU_NOT;
        w_next = S18;
      end
      S22: begin
        w_ctrl.addr2mux = A2_OFF9; w_ctrl.pcmux = PCMUX_ADDER; w_ctrl.ld_pc = 1'b1;
        w_next = S18;
      end
      S12, S20: begin
        w_ctrl.sr1mux   = 1'b1; w_ctrl.addr1mux = 1'b1;
        w_ctrl.addr2mux = A2_ZERO; w_ctrl.pcmux = PCMUX_ADDER; w_ctrl.ld_pc = 1'b1;
        w_next = S18;
      end
      S4: begin
        w_ctrl.gatepc = 1'b1; w_ctrl.drmux = 1'b1; w_ctrl.ld_reg = 1'b1;
        w_next = bus.IR_11 ? S21 : S20;
      end
      S21: begin
        w_ctrl.addr2mux = A2_OFF11; w_ctrl.pcmux = PCMUX_ADDER; w_ctrl.ld_pc = 1'b1;
        w_next = S18;
      end
      S6, S7: begin
        w_ctrl.gatemarmux = 1'b1; w_ctrl.ld_mar = 1'b1;
        w_ctrl.addr1mux   = 1'b1; w_ctrl.addr2mux = A2_OFF6;
        w_next = (r_state == S6) ? S25 : S23;
      end
      S27: begin
        w_ctrl.gatemdr = 1'b1; w_ctrl.ld_reg = 1'b1; w_ctrl.ld_cc = 1'b1;
        w_next = S18;
      end
      S23: begin
        w_ctrl.sr1mux  = 1'b0; w_ctrl.aluk = ALU_PASSA;
        w_ctrl.gatealu = 1'b1; w_ctrl.ld_mdr = 1'b1;
        w_next = S16;
      end
      S16: begin
        w_ctrl.mem_ce = 1'b0; w_ctrl.mem_we = 1'b0;
        if (w_timer_done) w_next = S18;
      end
      // Only reachable when the PAUSE instruction is enabled.
      PAUSE_IR1: if (Continue)  w_next = PAUSE_IR2;
      PAUSE_IR2: if (!Continue) w_next = S18;
      default: w_next = HALTED;
    endcase
  end

  assign bus.LD_MAR     = w_ctrl.ld_mar;
  assign bus.LD_MDR     = w_ctrl.ld_mdr;
  assign bus.LD_IR      = w_ctrl.ld_ir;
  assign bus.LD_PC      = w_ctrl.ld_pc;
  assign bus.LD_CC      = w_ctrl.ld_cc;
  assign bus.LD_BEN     = w_ctrl.ld_ben;
  assign bus.LD_REG     = w_ctrl.ld_reg;
  assign bus.GATEPC     = w_ctrl.gatepc;
  assign bus.GATEMDR    = w_ctrl.gatemdr;
  assign bus.GATEALU    = w_ctrl.gatealu;
  assign bus.GATEMARMUX = w_ctrl.gatemarmux;
  assign bus.DRMUX      = w_ctrl.drmux;
  assign bus.SR1MUX     = w_ctrl.sr1mux;
  assign bus.SR2MUX     = w_ctrl.sr2mux;
  assign bus.ADDR1MUX   = w_ctrl.addr1mux;
  assign bus.MIO_EN     = w_ctrl.mio_en;
  assign bus.PCMUX      = w_ctrl.pcmux;
  assign bus.ADDR2MUX   = w_ctrl.addr2mux;
  assign bus.ALUK       = w_ctrl.aluk;
  assign bus.Mem_CE     = w_ctrl.mem_ce;
  assign bus.Mem_UB     = w_ctrl.mem_ub;
  assign bus.Mem_LB     = w_ctrl.mem_lb;
  assign bus.Mem_OE     = w_ctrl.mem_oe;
  assign bus.Mem_WE     = w_ctrl.mem_we;

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control: two instances (MEM_WAIT=2 and 3) driven through their
// interfaces; expected states and control values are hand-derived per instruction.
module tb_lc3_control;
  import lc3_ctrl_pkg::*;

  logic Clk = 1'b0;
  logic Reset, Run2, Run3, Continue;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   gate_viol = 0;

  always #5 Clk = ~Clk;

  lc3_control_if bus2();
  lc3_control_if bus3();

  lc3_control #(.MEM_WAIT(2)) dut2 (.Clk(Clk), .Reset(Reset), .Run(Run2), .Continue(Continue), .bus(bus2));
  lc3_control #(.MEM_WAIT(3)) dut3 (.Clk(Clk), .Reset(Reset), .Run(Run3), .Continue(Continue), .bus(bus3));

  always @(negedge Clk) begin
    if (Reset) begin
      if ($countones({bus2.GATEPC, bus2.GATEMDR, bus2.GATEALU, bus2.GATEMARMUX}) > 1) gate_viol++;
      if ($countones({bus3.GATEPC, bus3.GATEMDR, bus3.GATEALU, bus3.GATEMARMUX}) > 1) gate_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
    bus2.Opcode = op; bus2.IR_5 = ir5; bus2.IR_11 = ir11; bus2.BEN = ben;
    bus3.Opcode = op; bus3.IR_5 = ir5; bus3.IR_11 = ir11; bus3.BEN = ben;
  endtask

  // Pulse reset, then a one-cycle Run on the chosen instance; returns in S18.
  task automatic restart(input bit which3);
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    if (which3) Run3 = 1'b1; else Run2 = 1'b1;
    tick();
    Run2 = 1'b0; Run3 = 1'b0;
  endtask

  task automatic fetch2(input string tag);
    restart(1'b0);
    repeat (4) tick();
    check(tag, 32'(dut2.r_state), 32'(S32));
  endtask

  task automatic wait_state3(input state_t target, input int budget, input string tag);
    int k = 0;
    while (dut3.r_state != target && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(dut3.r_state), 32'(target));
  endtask

  initial begin
    int n;
    Reset = 1'b0; Run2 = 1'b0; Run3 = 1'b0; Continue = 1'b0;
    set_in(4'h1, 1'b1, 1'b0, 1'b0);
    #3;
    check("rst_state",  32'(dut2.r_state), 32'(HALTED));
    check("rst_ld_mar", 32'(bus2.LD_MAR), 32'd0);
    check("rst_gatepc", 32'(bus2.GATEPC), 32'd0);
    check("rst_we",     32'(bus2.Mem_WE), 32'd1);
    check("rst_ce",     32'(bus2.Mem_CE), 32'd1);
    tick();
    Reset = 1'b1;
    set_in(4'hF, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_rst_halted", 32'(dut2.r_state), 32'(HALTED));

    // ADD from word 0x1261: IR_5=1, IR_11=0
    set_in(4'h1, 1'b1, 1'b0, 1'b0);
    restart(1'b0);
    check("add_s18",      32'(dut2.r_state), 32'(S18));
    check("s18_gatepc",   32'(bus2.GATEPC), 32'd1);
    check("s18_ldpc",     32'(bus2.LD_PC), 32'd1);
    check("s18_ldmar",    32'(bus2.LD_MAR), 32'd1);
    check("s18_pcmux",    32'(bus2.PCMUX), 32'd0);
    check("s18_ldreg",    32'(bus2.LD_REG), 32'd0);
    tick();
    check("add_s33a",     32'(dut2.r_state), 32'(S33));
    check("s33_oe",       32'(bus2.Mem_OE), 32'd0);
    check("s33_ce",       32'(bus2.Mem_CE), 32'd0);
    check("s33_mio",      32'(bus2.MIO_EN), 32'd1);
    check("s33_ldmdr",    32'(bus2.LD_MDR), 32'd1);
    check("s33a_ldreg",   32'(bus2.LD_REG), 32'd0);
    tick();
    check("add_s33b",     32'(dut2.r_state), 32'(S33));
    check("s33b_ldreg",   32'(bus2.LD_REG), 32'd0);
    tick();
    check("add_s35",      32'(dut2.r_state), 32'(S35));
    check("s35_gatemdr",  32'(bus2.GATEMDR), 32'd1);
    check("s35_ldir",     32'(bus2.LD_IR), 32'd1);
    check("s35_ldreg",    32'(bus2.LD_REG), 32'd0);
    tick();
    check("add_s32",      32'(dut2.r_state), 32'(S32));
    check("s32_ldben",    32'(bus2.LD_BEN), 32'd1);
    check("s32_ldreg",    32'(bus2.LD_REG), 32'd0);
    tick();
    check("add_s1",       32'(dut2.r_state), 32'(S1));
    check("s1_ldreg",     32'(bus2.LD_REG), 32'd1);
    check("s1_gatealu",   32'(bus2.GATEALU), 32'd1);
    check("s1_ldcc",      32'(bus2.LD_CC), 32'd1);
    check("s1_sr1mux",    32'(bus2.SR1MUX), 32'd1);
    check("s1_sr2mux",    32'(bus2.SR2MUX), 32'd1);
    check("s1_aluk",      32'(bus2.ALUK), 32'd0);
    tick();
    check("add_back_s18", 32'(dut2.r_state), 32'(S18));
    check("add_end_ldreg", 32'(bus2.LD_REG), 32'd0);

    set_in(4'h5, 1'b0, 1'b0, 1'b0);
    fetch2("and_s32"); tick();
    check("and_s5",     32'(dut2.r_state), 32'(S5));
    check("and_aluk",   32'(bus2.ALUK), 32'd1);
    check("and_sr2mux", 32'(bus2.SR2MUX), 32'd0);

    set_in(4'h9, 1'b1, 1'b0, 1'b0);
    fetch2("not_s32"); tick();
    check("not_s9",   32'(dut2.r_state), 32'(S9));
    check("not_aluk", 32'(bus2.ALUK), 32'd2);

    set_in(4'h0, 1'b0, 1'b0, 1'b0);
    fetch2("br0_s32");
    check("br0_ldpc", 32'(bus2.LD_PC), 32'd0);
    tick();
    check("br0_s18",  32'(dut2.r_state), 32'(S18));

    set_in(4'h0, 1'b0, 1'b0, 1'b1);
    fetch2("br1_s32"); tick();
    check("br1_s22",      32'(dut2.r_state), 32'(S22));
    check("br1_pcmux",    32'(bus2.PCMUX), 32'd2);
    check("br1_ldpc",     32'(bus2.LD_PC), 32'd1);
    check("br1_addr2mux", 32'(bus2.ADDR2MUX), 32'd2);
    check("br1_addr1mux", 32'(bus2.ADDR1MUX), 32'd0);

    set_in(4'hC, 1'b0, 1'b0, 1'b0);
    fetch2("jmp_s32"); tick();
    check("jmp_s12",      32'(dut2.r_state), 32'(S12));
    check("jmp_addr1mux", 32'(bus2.ADDR1MUX), 32'd1);
    check("jmp_addr2mux", 32'(bus2.ADDR2MUX), 32'd0);
    check("jmp_pcmux",    32'(bus2.PCMUX), 32'd2);
    check("jmp_ldpc",     32'(bus2.LD_PC), 32'd1);

    set_in(4'h4, 1'b0, 1'b1, 1'b0);
    fetch2("jsr_s32"); tick();
    check("jsr_s4",       32'(dut2.r_state), 32'(S4));
    check("jsr_drmux",    32'(bus2.DRMUX), 32'd1);
    check("jsr_ldreg",    32'(bus2.LD_REG), 32'd1);
    check("jsr_gatepc",   32'(bus2.GATEPC), 32'd1);
    tick();
    check("jsr_s21",      32'(dut2.r_state), 32'(S21));
    check("jsr_addr2mux", 32'(bus2.ADDR2MUX), 32'd3);
    check("jsr_pcmux",    32'(bus2.PCMUX), 32'd2);

    set_in(4'h4, 1'b0, 1'b0, 1'b0);
    fetch2("jsrr_s32"); tick(); tick();
    check("jsrr_s20", 32'(dut2.r_state), 32'(S20));
    check("jsrr_ldpc", 32'(bus2.LD_PC), 32'd1);

    set_in(4'h6, 1'b0, 1'b0, 1'b0);
    fetch2("ldr_s32"); tick();
    check("ldr_s6",       32'(dut2.r_state), 32'(S6));
    check("ldr_gatemar",  32'(bus2.GATEMARMUX), 32'd1);
    check("ldr_addr2mux", 32'(bus2.ADDR2MUX), 32'd1);
    tick();
    check("ldr_s25a",     32'(dut2.r_state), 32'(S25));
    check("ldr_oe",       32'(bus2.Mem_OE), 32'd0);
    tick();
    check("ldr_s25b",     32'(dut2.r_state), 32'(S25));
    tick();
    check("ldr_s27",      32'(dut2.r_state), 32'(S27));
    check("ldr_ldreg",    32'(bus2.LD_REG), 32'd1);
    check("ldr_gatemdr",  32'(bus2.GATEMDR), 32'd1);

    set_in(4'h7, 1'b0, 1'b0, 1'b0);
    fetch2("str2_s32"); tick();
    check("str2_s7", 32'(dut2.r_state), 32'(S7));
    tick();
    check("str2_s23",    32'(dut2.r_state), 32'(S23));
    check("str2_aluk",   32'(bus2.ALUK), 32'd3);
    check("str2_ldmdr",  32'(bus2.LD_MDR), 32'd1);
    check("str2_we_off", 32'(bus2.Mem_WE), 32'd1);
    tick();
    n = 0;
    while (bus2.Mem_WE == 1'b0 && n < 10) begin n++; tick(); end
    check("str2_we_len", 32'(n), 32'd2);
    check("str2_s18",    32'(dut2.r_state), 32'(S18));

    set_in(4'hF, 1'b0, 1'b0, 1'b0);
    fetch2("undef_s32"); tick();
    check("undef_s18", 32'(dut2.r_state), 32'(S18));

    set_in(4'hD, 1'b0, 1'b0, 1'b0);
    fetch2("pause_s32"); tick();
`ifdef LC3_PAUSE_EN
    check("pause_ir1",      32'(dut2.r_state), 32'(PAUSE_IR1));
    tick(); tick();
    check("pause_ir1_hold", 32'(dut2.r_state), 32'(PAUSE_IR1));
    Continue = 1'b1; tick();
    check("pause_ir2",      32'(dut2.r_state), 32'(PAUSE_IR2));
    tick();
    check("pause_ir2_hold", 32'(dut2.r_state), 32'(PAUSE_IR2));
    Continue = 1'b0; tick();
    check("pause_s18",      32'(dut2.r_state), 32'(S18));
`else
    check("pause_undef_s18", 32'(dut2.r_state), 32'(S18));
`endif

    set_in(4'h7, 1'b0, 1'b0, 1'b0);
    restart(1'b1);
    wait_state3(S23, 20, "str3_s23");
    tick();
    n = 0;
    while (bus3.Mem_WE == 1'b0 && n < 10) begin n++; tick(); end
    check("str3_we_len", 32'(n), 32'd3);
    check("str3_s18",    32'(dut3.r_state), 32'(S18));

    restart(1'b1);
    wait_state3(S16, 20, "midwr_s16");
    check("midwr_we_low", 32'(bus3.Mem_WE), 32'd0);
    #2 Reset = 1'b0;
    #1;
    check("midwr_we_high", 32'(bus3.Mem_WE), 32'd1);
    check("midwr_halted",  32'(dut3.r_state), 32'(HALTED));
    #2 Reset = 1'b1;

    restart(1'b0);
    for (int i = 0; i < 1500; i++) begin
      set_in(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      Continue = 1'($urandom_range(0, 1));
      tick();
    end
    check("gate_onehot_viol", 32'(gate_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
